// File: rtl/beta_pkg.sv
// Shared beta core types and constants used by the control sequencer.
package beta_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        DECODE,
        EXEC,
        TRAP
    } seq_state_t;

    localparam logic [3:0] TRAP_CAUSE_MISALIGNED = 4'd0;
    localparam logic [3:0] TRAP_CAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] TRAP_CAUSE_UOVERRUN   = 4'd15;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/beta_cu_sequencer.sv
// Multicycle fetch/decode/micro-step sequencer: fetches into the IR, walks the micro-ROM, commits or traps.
// Latency N+3 cycles per N-word instruction; fetch waits on gnt/rvalid, EXEC holds while ustall_i.
module beta_cu_sequencer #(
    parameter int unsigned          XLEN      = 32,
    parameter logic [XLEN-1:0]      BOOT_ADDR = '0,
    parameter logic [XLEN-1:0]      TRAP_VEC  = 'h100,
    parameter int unsigned          USTEP_W   = 3,
    parameter logic [XLEN-1:0]      NOP_INSTR = beta_pkg::NOP_INSTR
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    halt_i,
    output logic                    imem_req_o,
    output logic [XLEN-1:0]         imem_addr_o,
    input  logic                    imem_gnt_i,
    input  logic                    imem_rvalid_i,
    input  logic [XLEN-1:0]         imem_rdata_i,
    output logic [XLEN-1:0]         ir_o,
    input  logic [8:0]              cu_addr_i,
    input  logic                    invalid_instr_i,
    output logic [9+USTEP_W-1:0]    urom_addr_o,
    output logic                    urom_en_o,
    input  logic                    ustall_i,
    input  logic                    ulast_i,
    input  logic                    upc_we_i,
    input  logic [XLEN-1:0]         upc_i,
    output logic [XLEN-1:0]         pc_o,
    output logic                    instret_o,
    output logic                    trap_o,
    output logic [3:0]              trap_cause_o,
    output logic [XLEN-1:0]         trap_epc_o
);

    import beta_pkg::*;

    localparam logic [USTEP_W-1:0] USTEP_MAX = '1;

    seq_state_t             state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [XLEN-1:0]        ir_q, ir_d;
    logic [XLEN-1:0]        epc_q, epc_d;
    logic [USTEP_W-1:0]     ustep_q, ustep_d;
    logic [3:0]             cause_q, cause_d;
    logic [3:0]             tcause_q, tcause_d;
    logic                   instret_q, instret_d;

    logic                   target_misaligned;
    logic [XLEN-1:0]        pc_commit;

    assign target_misaligned = upc_we_i && (upc_i[1:0] != 2'b00);
    assign pc_commit         = upc_we_i ? upc_i : pc_q + XLEN'(4);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        epc_d     = epc_q;
        ustep_d   = ustep_q;
        cause_d   = cause_q;
        tcause_d  = tcause_q;
        instret_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!halt_i) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (imem_gnt_i) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (invalid_instr_i) begin
                    cause_d = TRAP_CAUSE_ILLEGAL;
                    state_d = TRAP;
                end else begin
                    ustep_d = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Stall outranks ulast_i so a stalled last word never commits early.
                if (ustall_i) begin
                    state_d = EXEC;
                end else if (ulast_i && target_misaligned) begin
                    cause_d = TRAP_CAUSE_MISALIGNED;
                    state_d = TRAP;
                end else if (ulast_i) begin
                    pc_d      = pc_commit;
                    instret_d = 1'b1;
                    state_d   = halt_i ? IDLE : FETCH_REQ;
                end else if (ustep_q == USTEP_MAX) begin
                    cause_d = TRAP_CAUSE_UOVERRUN;
                    state_d = TRAP;
                end else begin
                    ustep_d = ustep_q + 1'b1;
                end
            end
            TRAP: begin
                tcause_d = cause_q;
                epc_d    = pc_q;
                pc_d     = TRAP_VEC;
                ustep_d  = '0;
                state_d  = FETCH_REQ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            pc_q      <= BOOT_ADDR;
            ir_q      <= NOP_INSTR;
            epc_q     <= '0;
            ustep_q   <= '0;
            cause_q   <= TRAP_CAUSE_MISALIGNED;
            tcause_q  <= '0;
            instret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            epc_q     <= epc_d;
            ustep_q   <= ustep_d;
            cause_q   <= cause_d;
            tcause_q  <= tcause_d;
            instret_q <= instret_d;
        end
    end

    assign imem_req_o   = (state_q == FETCH_REQ);
    assign urom_en_o    = (state_q == EXEC);
    assign trap_o       = (state_q == TRAP);
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign ir_o         = ir_q;
    assign urom_addr_o  = {cu_addr_i, ustep_q};
    assign instret_o    = instret_q;
    assign trap_cause_o = tcause_q;
    assign trap_epc_o   = epc_q;

endmodule

// File: tb/tb_beta_cu_sequencer.sv
// Directed + randomized bench for beta_cu_sequencer against an instruction-level PC/trap model.
module tb_beta_cu_sequencer;

    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] ir_o;
    logic [8:0]  cu_addr_i = '0;
    logic        invalid_instr_i = 1'b0;
    logic [11:0] urom_addr_o;
    logic        urom_en_o;
    logic        ustall_i = 1'b0;
    logic        ulast_i = 1'b0;
    logic        upc_we_i = 1'b0;
    logic [31:0] upc_i = '0;
    logic [31:0] pc_o;
    logic        instret_o;
    logic        trap_o;
    logic [3:0]  trap_cause_o;
    logic [31:0] trap_epc_o;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc   = '0;
    logic [31:0] last_ir  = NOP;

    beta_cu_sequencer dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .halt_i         (halt_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .ir_o           (ir_o),
        .cu_addr_i      (cu_addr_i),
        .invalid_instr_i(invalid_instr_i),
        .urom_addr_o    (urom_addr_o),
        .urom_en_o      (urom_en_o),
        .ustall_i       (ustall_i),
        .ulast_i        (ulast_i),
        .upc_we_i       (upc_we_i),
        .upc_i          (upc_i),
        .pc_o           (pc_o),
        .instret_o      (instret_o),
        .trap_o         (trap_o),
        .trap_cause_o   (trap_cause_o),
        .trap_epc_o     (trap_epc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Trap entry: one TRAP cycle (halt ignored), then cause/epc visible and fetch from TRAP_VEC.
    task automatic expect_trap(input logic [3:0] cause);
        chk("trap_pulse", {31'b0, trap_o}, 32'd1);
        chk("trap_no_instret", {31'b0, instret_o}, 32'd0);
        chk("trap_pc_unchanged", pc_o, exp_pc);
        halt_i = 1'b1;
        @(negedge clk_i);
        halt_i = 1'b0;
        chk("trap_pulse_end", {31'b0, trap_o}, 32'd0);
        chk("trap_cause", {28'b0, trap_cause_o}, {28'b0, cause});
        chk("trap_epc", trap_epc_o, exp_pc);
        exp_pc = TRAP_VEC;
        chk("trap_vec_pc", pc_o, exp_pc);
        chk("trap_refetch_req", {31'b0, imem_req_o}, 32'd1);
    endtask

    // One instruction end-to-end. nwords==0 means ulast_i is never raised.
    task automatic run_instr(input logic [31:0] instr, input int gnt_dly, input int rv_dly,
                             input bit invalid, input int nwords, input int nstall,
                             input bit jump, input logic [31:0] target, input bit halt_after);
        logic [8:0] cu;
        int t, k, execs, stall_left;
        bit is_last, stalled;
        cu = 9'($urandom);
        t = 0;
        while (imem_req_o !== 1'b1 && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("fetch_req_seen", {31'b0, imem_req_o}, 32'd1);
        chk("fetch_addr", imem_addr_o, exp_pc);
        for (int i = 0; i < gnt_dly; i++) begin
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = ~instr;
            @(negedge clk_i);
            chk("req_hold", {31'b0, imem_req_o}, 32'd1);
            chk("addr_hold", imem_addr_o, exp_pc);
            chk("ir_hold_req", ir_o, last_ir);
        end
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        @(negedge clk_i);
        imem_gnt_i = 1'b0;
        chk("req_drop", {31'b0, imem_req_o}, 32'd0);
        for (int i = 0; i < rv_dly; i++) begin
            @(negedge clk_i);
            chk("ir_hold_wait", ir_o, last_ir);
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = instr;
        @(negedge clk_i);
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        chk("ir_load", ir_o, instr);
        last_ir = instr;
        chk("decode_uen_off", {31'b0, urom_en_o}, 32'd0);
        cu_addr_i       = cu;
        invalid_instr_i = invalid;
        @(negedge clk_i);
        invalid_instr_i = 1'b0;
        if (invalid) begin
            expect_trap(4'd2);
            return;
        end

        k = 0;
        execs = 0;
        stall_left = nstall;
        for (int c = 0; c < 64; c++) begin
            chk("exec_uen", {31'b0, urom_en_o}, 32'd1);
            chk("exec_uaddr", {20'b0, urom_addr_o}, {20'b0, cu, 3'(k)});
            chk("exec_no_instret", {31'b0, instret_o}, 32'd0);
            execs++;
            is_last = (nwords != 0) && (k == nwords - 1);
            stalled = is_last && (stall_left > 0);
            upc_we_i = jump;
            upc_i    = target;
            if (stalled) begin
                ustall_i = 1'b1;
                ulast_i  = 1'b1;
                stall_left--;
            end else if (is_last) begin
                ustall_i = 1'b0;
                ulast_i  = 1'b1;
                halt_i   = halt_after;
            end else begin
                ustall_i = 1'b0;
                ulast_i  = 1'b0;
                upc_we_i = 1'($urandom);
                upc_i    = $urandom;
            end
            @(negedge clk_i);
            ustall_i = 1'b0;
            ulast_i  = 1'b0;
            upc_we_i = 1'b0;
            if (is_last && !stalled) break;
            if (!is_last && k == 7) break;
            if (!stalled) k++;
        end
        chk("exec_cycles", execs, (nwords == 0) ? 8 : nwords + nstall);

        if (nwords == 0) begin
            expect_trap(4'd15);
        end else if (jump && target[1:0] != 2'b00) begin
            expect_trap(4'd0);
        end else begin
            exp_pc = jump ? target : exp_pc + 32'd4;
            chk("commit_instret", {31'b0, instret_o}, 32'd1);
            chk("commit_pc", pc_o, exp_pc);
            if (halt_after) begin
                for (int i = 0; i < 3; i++) begin
                    chk("halt_req_low", {31'b0, imem_req_o}, 32'd0);
                    @(negedge clk_i);
                    chk("halt_no_instret", {31'b0, instret_o}, 32'd0);
                end
                halt_i = 1'b0;
                @(negedge clk_i);
                chk("halt_release_req", {31'b0, imem_req_o}, 32'd1);
            end else begin
                chk("back_to_back_req", {31'b0, imem_req_o}, 32'd1);
            end
        end
    endtask

    initial begin
        int nw, gd, rd, ns;
        bit inv, jmp, hlt;
        logic [31:0] tgt;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_ir", ir_o, NOP);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_uen", {31'b0, urom_en_o}, 32'd0);
        chk("rst_instret", {31'b0, instret_o}, 32'd0);
        chk("rst_trap", {31'b0, trap_o}, 32'd0);
        chk("rst_cause", {28'b0, trap_cause_o}, 32'd0);
        chk("rst_epc", trap_epc_o, 32'h0);
        imem_gnt_i = 1'b1;
        rstn_i = 1'b1;
        #1;
        chk("req_low_at_release", {31'b0, imem_req_o}, 32'd0);
        @(negedge clk_i);
        chk("req_after_release", {31'b0, imem_req_o}, 32'd1);
        chk("addr_after_release", imem_addr_o, 32'h0);
        imem_gnt_i = 1'b0;

        // Directed sequence
        run_instr(32'h0050_0093, 2, 0, 1'b0, 2, 0, 1'b0, 32'h0, 1'b0);
        chk("pc_after_first", pc_o, 32'h4);
        run_instr(32'h0000_0033, 0, 0, 1'b0, 1, 3, 1'b0, 32'h0, 1'b0);
        run_instr(32'hFFFF_FFFF, 1, 1, 1'b1, 1, 0, 1'b0, 32'h0, 1'b0);
        run_instr(32'h0220_006F, 0, 0, 1'b0, 3, 0, 1'b1, 32'h22, 1'b0);
        run_instr(32'h0400_006F, 0, 0, 1'b0, 2, 0, 1'b1, 32'h40, 1'b0);
        chk("jump_target_pc", pc_o, 32'h40);
        run_instr(32'h0000_0013, 0, 0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
        run_instr(32'h0010_0113, 0, 0, 1'b0, 2, 0, 1'b0, 32'h0, 1'b1);
        run_instr(32'h0000_0067, 0, 0, 1'b0, 1, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        run_instr(32'h0000_0013, 0, 0, 1'b0, 8, 1, 1'b0, 32'h0, 1'b0);
        chk("pc_wrap", pc_o, 32'h0);

        // Randomized instructions
        for (int n = 0; n < 40; n++) begin
            nw  = $urandom_range(1, 8);
            if ($urandom_range(0, 9) == 0) nw = 0;
            inv = ($urandom_range(0, 7) == 0);
            jmp = 1'($urandom);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC;
            ns  = $urandom_range(0, 2);
            hlt = ($urandom_range(0, 5) == 0);
            gd  = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            run_instr($urandom, gd, rd, inv, nw, ns, jmp, tgt, hlt);
        end

        // Reset while waiting for fetch data; the late rvalid must be dropped.
        while (imem_req_o !== 1'b1) @(negedge clk_i);
        imem_gnt_i = 1'b1;
        @(negedge clk_i);
        imem_gnt_i = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        chk("midrst_pc", pc_o, 32'h0);
        chk("midrst_ir", ir_o, NOP);
        chk("midrst_req", {31'b0, imem_req_o}, 32'd0);
        chk("midrst_cause", {28'b0, trap_cause_o}, 32'd0);
        chk("midrst_epc", trap_epc_o, 32'h0);
        exp_pc  = 32'h0;
        last_ir = NOP;
        halt_i  = 1'b1;
        @(negedge clk_i);
        rstn_i        = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        repeat (2) begin
            @(negedge clk_i);
            chk("midrst_ir_ignored", ir_o, NOP);
            chk("midrst_idle_req", {31'b0, imem_req_o}, 32'd0);
        end
        imem_rvalid_i = 1'b0;
        halt_i = 1'b0;
        run_instr(32'h0000_0093, 1, 0, 1'b0, 2, 0, 1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/beta_cu_sequencer.md
Name: beta_cu_sequencer

Overview:
Multicycle control sequencer for the beta core. It fetches an instruction over a req/gnt/rvalid memory handshake and latches it into the instruction register that feeds beta_decoder. It then steps the micro-ROM through the addressed micro-program and commits the PC. Illegal instructions, runaway micro-programs and misaligned jump targets are redirected to a trap vector.

Parameters:
XLEN, 32, datapath and address width
BOOT_ADDR, 32'h0000_0000, PC value after reset
TRAP_VEC, 32'h0000_0100, PC loaded on any trap
USTEP_W, 3, micro-step counter width; at most 2^USTEP_W micro-words per instruction
NOP_INSTR, 32'h0000_0013, IR reset value (ADDI x0,x0,0)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous reset, active low
halt_i  in  1  hold the sequencer in IDLE at the next instruction boundary
imem_req_o  out  1  fetch request
imem_addr_o  out  XLEN  fetch address, always equal to the PC
imem_gnt_i  in  1  request accepted
imem_rvalid_i  in  1  fetch data valid
imem_rdata_i  in  XLEN  fetched instruction
ir_o  out  XLEN  instruction register, drives beta_decoder instr_i
cu_addr_i  in  9  micro-ROM base address from the decoder
invalid_instr_i  in  1  illegal instruction flag from the decoder
urom_addr_o  out  9+USTEP_W  micro-ROM address, {cu_addr_i, ustep}
urom_en_o  out  1  micro-ROM word is being executed
ustall_i  in  1  current micro-word waits (for example on data memory)
ulast_i  in  1  current micro-word is the last of its program
upc_we_i  in  1  micro-word redirects the PC
upc_i  in  XLEN  redirect target
pc_o  out  XLEN  current PC
instret_o  out  1  one-cycle pulse when an instruction commits
trap_o  out  1  one-cycle pulse on trap entry
trap_cause_o  out  4  cause: 0 misaligned target, 2 illegal instruction, 15 micro-program overrun
trap_epc_o  out  XLEN  PC of the trapping instruction

Behaviour:
- Reset (asynchronous, rstn_i low), all values apply immediately:
  - state = IDLE, pc = BOOT_ADDR, ir = NOP_INSTR, ustep = 0
  - trap_cause_o = 0, trap_epc_o = 0
  - imem_req_o, urom_en_o, instret_o, trap_o = 0
- A reset mid-fetch abandons the transaction; any later rvalid is ignored because the state is IDLE.
- Decoded outputs:
  - imem_req_o = (state == FETCH_REQ)
  - urom_en_o = (state == EXEC)
  - imem_addr_o = pc_o = pc
  - urom_addr_o = {cu_addr_i, ustep}
- States and transitions:
  - IDLE: if halt_i is high, stay; otherwise go to FETCH_REQ.
  - FETCH_REQ: req stays high and addr stays stable until imem_gnt_i. On gnt, go to FETCH_WAIT.
  - FETCH_WAIT: on imem_rvalid_i, ir <= imem_rdata_i and go to DECODE. rvalid arrives no earlier than the cycle after gnt; rvalid seen in FETCH_REQ is ignored.
  - DECODE: one cycle, so the decoder settles on the new IR. If invalid_instr_i, go to TRAP with cause 2. Otherwise ustep <= 0 and go to EXEC.
  - EXEC, evaluated in priority order:
    1. ustall_i: hold ustep and the state.
    2. ulast_i with upc_we_i and upc_i[1:0] != 0: go to TRAP with cause 0; the PC is not updated.
    3. ulast_i (otherwise): commit. pc <= upc_we_i ? upc_i : pc + 4 (wraps modulo 2^XLEN). instret_o pulses in the following cycle. Next state is IDLE if halt_i, else FETCH_REQ.
    4. ustep == 2^USTEP_W - 1 without ulast_i: go to TRAP with cause 15.
    5. Otherwise: ustep <= ustep + 1.
  - TRAP: one cycle.
    - trap_o = 1, trap_epc_o <= pc, trap_cause_o <= latched cause
    - pc <= TRAP_VEC, ustep <= 0
    - go to FETCH_REQ; halt_i is not honoured at trap entry.
- trap_cause_o and trap_epc_o hold their value until the next trap.
- ir_o changes only on an accepted rvalid.
- A stall on the last micro-word delays the commit. ulast_i is honoured only in a non-stalled cycle.
- Minimum latency per instruction: 1 (FETCH_REQ, gnt same cycle) + 1 (FETCH_WAIT, rvalid next cycle) + 1 (DECODE) + N micro-words = N + 3 cycles. Back-to-back instructions do not pass through IDLE.

Decomposition:
- beta_pkg gains:
  - seq_state_t enum {IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, TRAP}
  - constants TRAP_CAUSE_MISALIGNED = 4'd0, TRAP_CAUSE_ILLEGAL = 4'd2, TRAP_CAUSE_UOVERRUN = 4'd15, NOP_INSTR
- No sub-module is needed. The PC/IR register block stays inline.

Test Plan:
- Reset then release, gnt asserted immediately:
  - imem_req_o rises 1 cycle after release with imem_addr_o = 0x0
  - while rstn_i is low: ir_o = 0x13 and pc_o = 0x0
- Fetch 0x00500093 with gnt after 2 cycles, rvalid 1 cycle later, micro-program of 2 words (ulast_i on the second):
  - ir_o = 0x00500093
  - urom_addr_o steps {cu,0} then {cu,1}
  - instret_o pulses once
  - next fetch address = 0x4
- ustall_i held 3 cycles on the last word:
  - ustep is frozen and the commit is delayed by exactly 3 cycles
- invalid_instr_i high in DECODE at pc = 0x8:
  - trap_o pulses with trap_cause_o = 2 and trap_epc_o = 0x8
  - next fetch address = 0x100
  - no instret_o pulse
- Jump micro-word with upc_i = 0x22: trap cause 0, epc = current pc. With upc_i = 0x40: next fetch address = 0x40.
- ulast_i never asserted: trap cause 15 after 8 EXEC cycles.
- halt_i asserted during EXEC: after the commit, the sequencer stays in IDLE with req low until halt_i drops.
